// File: rtl/pop_cycle_sequencer.sv
// Pulsed-optical-pumping cycle sequencer: pump, Ramsey MW pair, probe with sample window.
// All gates are registered from the next-state decode so they change on the same edge as the state.
module pop_cycle_sequencer #(
  parameter int PUMP_TICKS   = 1000,
  parameter int DEAD_TICKS   = 250,
  parameter int MW_TICKS     = 750,
  parameter int RAMSEY_TICKS = 12500,
  parameter int PROBE_TICKS  = 1250,
  parameter int SAMPLE_DELAY = 125,
  parameter int SAMPLE_TICKS = 1000,
  parameter int CNT_W        = 16
) (
  input  logic             clock_2_5M,
  input  logic             reset_n,
  input  logic             enable,
  output logic             pump,
  output logic             probe,
  output logic             MW,
  output logic             sample,
  output logic             cycle_start,
  output logic             busy,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] cycle_count
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_TICKS = max2(max2(max2(PUMP_TICKS, DEAD_TICKS), max2(MW_TICKS, RAMSEY_TICKS)),
                                  PROBE_TICKS);
  localparam int TW = $clog2(MAX_TICKS + 1);

  // Sample window expressed in down-counter values: probe tick t has counter PROBE_TICKS-1-t.
  localparam int SAMPLE_HI_CNT = PROBE_TICKS - 1 - SAMPLE_DELAY;
  localparam int SAMPLE_LO_CNT = PROBE_TICKS - SAMPLE_DELAY - SAMPLE_TICKS;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PUMP   = 3'd1,
    DEAD1  = 3'd2,
    MW1    = 3'd3,
    RAMSEY = 3'd4,
    MW2    = 3'd5,
    DEAD2  = 3'd6,
    PROBE  = 3'd7
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] tick, tick_d;
  logic          start_d;
  logic          pump_d, mw_d, probe_d, sample_d;

  function automatic logic [TW-1:0] last_tick(input state_t s);
    case (s)
      PUMP:        return TW'(PUMP_TICKS - 1);
      DEAD1:       return TW'(DEAD_TICKS - 1);
      MW1:         return TW'(MW_TICKS - 1);
      RAMSEY:      return TW'(RAMSEY_TICKS - 1);
      MW2:         return TW'(MW_TICKS - 1);
      DEAD2:       return TW'(DEAD_TICKS - 1);
      PROBE:       return TW'(PROBE_TICKS - 1);
      default:     return '0;
    endcase
  endfunction

  // Next state and next tick value. enable only matters in IDLE and on the last PROBE tick.
  always_comb begin
    state_d = state;
    tick_d  = tick;
    start_d = 1'b0;
    if (state == IDLE) begin
      if (enable) begin
        state_d = PUMP;
        start_d = 1'b1;
      end
    end else if (tick != '0) begin
      tick_d = tick - TW'(1);
    end else begin
      case (state)
        PUMP:    state_d = DEAD1;
        DEAD1:   state_d = MW1;
        MW1:     state_d = RAMSEY;
        RAMSEY:  state_d = MW2;
        MW2:     state_d = DEAD2;
        DEAD2:   state_d = PROBE;
        PROBE: begin
          state_d = enable ? PUMP : IDLE;
          start_d = enable;
        end
        default: state_d = IDLE;
      endcase
    end
    if ((state_d != state) || start_d) begin
      tick_d = last_tick(state_d);
    end
  end

  always_comb begin
    pump_d   = (state_d == PUMP);
    mw_d     = (state_d == MW1) || (state_d == MW2);
    probe_d  = (state_d == PROBE);
    sample_d = probe_d && (int'(tick_d) <= SAMPLE_HI_CNT) && (int'(tick_d) >= SAMPLE_LO_CNT);
  end

  always_ff @(posedge clock_2_5M or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tick        <= '0;
      pump        <= 1'b0;
      MW          <= 1'b0;
      probe       <= 1'b0;
      sample      <= 1'b0;
      cycle_start <= 1'b0;
      busy        <= 1'b0;
      phase       <= 3'd0;
      cycle_count <= '0;
    end else begin
      state       <= state_d;
      tick        <= tick_d;
      pump        <= pump_d;
      MW          <= mw_d;
      probe       <= probe_d;
      sample      <= sample_d;
      cycle_start <= start_d;
      busy        <= (state_d != IDLE);
      phase       <= state_d;
      if (start_d) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pop_cycle_sequencer.sv
// Bench for pop_cycle_sequencer: per-cycle vector table built from phase durations,
// hand sequences for async reset, random-enable invariants and the default-build period.
module tb_pop_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       en_def = 1'b0;

  logic       pump, probe, mw, sample, cycle_start, busy;
  logic [2:0] phase;
  logic [1:0] cycle_count;

  logic        pump_x, probe_x, mw_x, sample_x, cs_x, busy_x;
  logic [2:0]  phase_x;
  logic [15:0] count_x;

  int n_checks = 0;
  int n_err    = 0;
  int exp_count = 0;

  typedef struct {
    logic        en;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pop_cycle_sequencer #(
    .PUMP_TICKS(4), .DEAD_TICKS(2), .MW_TICKS(3), .RAMSEY_TICKS(5), .PROBE_TICKS(6),
    .SAMPLE_DELAY(1), .SAMPLE_TICKS(3), .CNT_W(2)
  ) u_dut (
    .clock_2_5M(clk), .reset_n(rst_n), .enable(enable),
    .pump(pump), .probe(probe), .MW(mw), .sample(sample),
    .cycle_start(cycle_start), .busy(busy), .phase(phase), .cycle_count(cycle_count)
  );

  pop_cycle_sequencer u_def (
    .clock_2_5M(clk), .reset_n(rst_n), .enable(en_def),
    .pump(pump_x), .probe(probe_x), .MW(mw_x), .sample(sample_x),
    .cycle_start(cs_x), .busy(busy_x), .phase(phase_x), .cycle_count(count_x)
  );

  function automatic logic [10:0] actual();
    return {phase, pump, mw, probe, sample, cycle_start, busy, cycle_count};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dur(input int p);
    case (p)
      1: return 4;
      2: return 2;
      3: return 3;
      4: return 5;
      5: return 3;
      6: return 2;
      7: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [10:0] exp_row(input int p, input int t, input int cnt);
    logic [2:0] ph;
    logic [1:0] c;
    logic pu, m, pr, s, cs, b;
    ph = 3'(p);
    c  = 2'(cnt);
    pu = (p == 1);
    m  = (p == 3) || (p == 5);
    pr = (p == 7);
    s  = pr && (t >= 1) && (t <= 3);
    cs = (p == 1) && (t == 0);
    b  = (p != 0);
    return {ph, pu, m, pr, s, cs, b, c};
  endfunction

  // One full cycle; rows with index < drop_at are applied with enable=1.
  task automatic add_cycle(input int drop_at);
    int idx;
    vec_t v;
    idx = 0;
    exp_count = (exp_count + 1) % 4;
    for (int p = 1; p <= 7; p++) begin
      for (int t = 0; t < dur(p); t++) begin
        v.en  = (idx < drop_at);
        v.exp = exp_row(p, t, exp_count);
        vecs.push_back(v);
        idx++;
      end
    end
  endtask

  task automatic add_idle(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.en  = 1'b0;
      v.exp = exp_row(0, 0, exp_count);
      vecs.push_back(v);
    end
  endtask

  task automatic run_vectors(input string tag);
    foreach (vecs[i]) begin
      @(negedge clk);
      enable = vecs[i].en;
      @(posedge clk);
      #1;
      check($sformatf("%s_row%0d", tag, i), 32'(actual()), 32'(vecs[i].exp));
    end
    vecs.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
  endtask

  // Every pump pulse must be exactly PUMP_TICKS long.
  int pump_run = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pump_run = 0;
    end else if (pump) begin
      pump_run++;
    end else begin
      if (pump_run != 0) check("pump_len", 32'(pump_run), 32'd4);
      pump_run = 0;
    end
  end

  initial begin
    int n;
    int one_hot;

    // Reset held: toggling enable must have no effect.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      enable = 1'(i % 2);
      @(posedge clk);
      #1;
      check("reset_hold", 32'(actual()), 32'd0);
    end
    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b1;
    en_def = 1'b1;

    // Single 1-tick enable pulse yields exactly one cycle.
    add_idle(1);
    add_cycle(1);
    add_idle(3);
    run_vectors("single");

    // Continuous run with counter wrap.
    pulse_reset();
    add_idle(1);
    add_cycle(25);
    add_cycle(25);
    add_cycle(25);
    add_cycle(1);
    add_idle(2);
    run_vectors("continuous");

    // Enable dropped during RAMSEY of cycle 2: cycle 2 still completes.
    add_cycle(25);
    add_cycle(12);
    add_idle(3);
    run_vectors("early_stop");

    // Async reset while probe and sample are high.
    add_cycle(1);
    while (vecs.size() > 22) void'(vecs.pop_back());
    run_vectors("pre_reset");
    check("sample_before_reset", 32'(sample), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'(actual()), 32'd0);
    @(posedge clk);
    #1;
    check("async_reset_hold", 32'(actual()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    add_idle(3);
    add_cycle(1);
    add_idle(1);
    run_vectors("restart");

    // Random enable with invariants checked every cycle.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
      one_hot = int'(pump) + int'(mw) + int'(probe);
      check("one_gate", 32'(one_hot <= 1), 32'd1);
      check("sample_implies_probe", 32'(sample & ~probe), 32'd0);
      check("busy_phase", 32'(busy), 32'(phase != 3'd0));
    end
    @(negedge clk);
    enable = 1'b0;

    // Default build period between cycle_start strobes.
    n = 0;
    while (!cs_x && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("default_first_start", 32'(cs_x), 32'd1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!cs_x && n < 20000);
    check("default_period", 32'(n), 32'd16750);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
